mux_nx1_arb: RTL and testbench

MUX_NX1_ARB -- requirements
Module: mux_nx1_arb

---
 rtl/mux_nx1_arb.sv | 85 ++++++++
 tb/tb_mux_nx1_arb.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_arb.sv
// N-to-1 registered multiplexer with explicit-select or round-robin arbitration.
// One-deep output register with ready/valid handshake on both sides.
module mux_nx1_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned NU = N;

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_vld;
  logic             load_en;
  logic [WIDTH-1:0] grant_word;

  assign load_en = !out_valid || out_ready;

  always_comb begin
    int unsigned idx;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    if (!mode) begin
      // Matching sel against each legal index rejects sel >= N without a range compare.
      for (int unsigned i = 0; i < NU; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_idx = SEL_W'(i);
          grant_vld = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < NU; k++) begin
        idx = (32'(rr_ptr) + k) % NU;
        if (!grant_vld && in_valid[idx]) begin
          grant_idx = SEL_W'(idx);
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_word = in_data[grant_idx*WIDTH +: WIDTH];
    in_ready   = '0;
    if (!reset && grant_vld && load_en)
      in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (grant_vld) begin
        out_valid <= 1'b1;
        out_data  <= grant_word;
        out_src   <= grant_idx;
        if (mode) begin
          if (grant_idx == SEL_W'(NU - 1))
            rr_ptr <= '0;
          else
            rr_ptr <= grant_idx + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Directed bench for mux_nx1_arb (WIDTH=32, N=4): vector table plus
// hand-written reset, backpressure and mid-operation reset sequences.
module tb_mux_nx1_arb;

  logic         clk;
  logic         reset;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic         mode;
  logic [1:0]   sel;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  ch [4];

  int total;
  int bad;

  mux_nx1_arb #(.WIDTH(32), .N(4)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .out_data (out_data),
    .out_src  (out_src),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign in_data = {ch[3], ch[2], ch[1], ch[0]};

  typedef struct {
    logic [3:0]  iv;
    logic        mode;
    logic [1:0]  sel;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_src;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [1:0] src,
                         input logic [31:0] data);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".out_src"}, 32'(out_src), 32'(src));
    chk({tag, ".out_data"}, out_data, data);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ch[0] = 32'd100;
    ch[1] = 32'd2;
    ch[2] = 32'h0000_2222;
    ch[3] = 32'h0000_3333;

    //               iv       md    sel    rdy   exp_rdy  ov    src    data
    vecs[0]  = '{4'b0011, 1'b0, 2'd1, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd2};
    vecs[1]  = '{4'b0011, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd100};
    vecs[2]  = '{4'b0011, 1'b0, 2'd2, 1'b1, 4'b0000, 1'b0, 2'd0, 32'd100};
    vecs[3]  = '{4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd100};
    vecs[4]  = '{4'b1111, 1'b1, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd2};
    vecs[5]  = '{4'b1111, 1'b1, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h2222};
    vecs[6]  = '{4'b1111, 1'b1, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h3333};
    vecs[7]  = '{4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd100};
    vecs[8]  = '{4'b0100, 1'b1, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h2222};
    vecs[9]  = '{4'b0101, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd100};
    vecs[10] = '{4'b0101, 1'b1, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h2222};
    vecs[11] = '{4'b1000, 1'b0, 2'd3, 1'b0, 4'b0000, 1'b1, 2'd2, 32'h2222};
    vecs[12] = '{4'b1000, 1'b0, 2'd3, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h3333};
    vecs[13] = '{4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd3, 32'h3333};
    vecs[14] = '{4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd3, 32'h3333};
    vecs[15] = '{4'b1001, 1'b1, 2'd0, 1'b0, 4'b1000, 1'b1, 2'd3, 32'h3333};

    // Reset held two cycles with all channels offering
    reset     = 1'b1;
    in_valid  = 4'b1111;
    mode      = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b1;
    #1;
    chk("rst.in_ready0", 32'(in_ready), 32'h0);
    tick();
    chk("rst.in_ready1", 32'(in_ready), 32'h0);
    tick();
    chk("rst.in_ready2", 32'(in_ready), 32'h0);
    chk_out("rst", 1'b0, 2'd0, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      in_valid  = vecs[i].iv;
      mode      = vecs[i].mode;
      sel       = vecs[i].sel;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      tick();
      chk_out($sformatf("v%0d", i), vecs[i].exp_ov, vecs[i].exp_src, vecs[i].exp_data);
    end

    // Backpressure: hold 0xDEADBEEF for 3 stalled cycles, mode/sel churn must not disturb it
    ch[1]     = 32'hDEAD_BEEF;
    mode      = 1'b0;
    sel       = 2'd1;
    in_valid  = 4'b0010;
    out_ready = 1'b1;
    tick();
    chk_out("bp.load", 1'b1, 2'd1, 32'hDEAD_BEEF);
    ch[1]     = 32'h1234_5678;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        mode     = 1'b1;
        in_valid = 4'b1111;
      end
      #1;
      chk($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'h0);
      tick();
      chk_out($sformatf("bp%0d", i), 1'b1, 2'd1, 32'hDEAD_BEEF);
    end
    mode      = 1'b0;
    sel       = 2'd1;
    in_valid  = 4'b0010;
    out_ready = 1'b1;
    #1;
    chk("bp.release.in_ready", 32'(in_ready), 32'h2);
    tick();
    chk_out("bp.release", 1'b1, 2'd1, 32'h1234_5678);

    // Advance rr_ptr to 1, then reset mid-operation; arbitration must restart at channel 0
    mode     = 1'b1;
    in_valid = 4'b0001;
    tick();
    chk_out("pre_rst", 1'b1, 2'd0, 32'd100);
    in_valid = 4'b1111;
    reset    = 1'b1;
    #1;
    chk("mid_rst.in_ready", 32'(in_ready), 32'h0);
    tick();
    chk_out("mid_rst", 1'b0, 2'd0, 32'h0);
    reset = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'h1);
    tick();
    chk_out("post_rst", 1'b1, 2'd0, 32'd100);
    #1;
    chk("post_rst2.in_ready", 32'(in_ready), 32'h2);
    tick();
    chk_out("post_rst2", 1'b1, 2'd1, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
